// File: rtl/sd_sector_responder.sv
// SD sector-buffer target: serves 512-byte sector reads/writes from a local byte store.
// Define SD_SECTOR_RESPONDER_STATS_EN to add sector counters and a sticky out-of-range flag.
module sd_sector_responder #(
  parameter int LBA_WIDTH   = 4,
  parameter int NUM_SECTORS = 16,
  parameter int ACK_DELAY   = 2
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic [31:0]          sd_lba,
  input  logic                 sd_rd,
  input  logic                 sd_wr,
  output logic                 sd_ack,
  output logic [8:0]           sd_buff_addr,
  output logic [7:0]           sd_buff_dout,
  output logic                 sd_buff_wr,
  input  logic [7:0]           sd_buff_din,
  output logic [LBA_WIDTH+8:0] mem_addr,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic [7:0]           mem_dout,
  input  logic [7:0]           mem_din,
  input  logic                 mem_ready
`ifdef SD_SECTOR_RESPONDER_STATS_EN
  ,
  output logic [15:0]          rd_sectors,
  output logic [15:0]          wr_sectors,
  output logic                 oor_seen
`endif
);

  localparam logic [3:0] ACK_LAST = 4'(ACK_DELAY - 1);

  typedef enum logic [3:0] {
    IDLE, ACKWAIT, RD_REQ, RD_WAIT, RD_STB, WR_ADDR, WR_DATA, WR_WAIT, DONE
  } state_t;

  state_t               state, state_nxt;
  logic [LBA_WIDTH-1:0] lba_q;
  logic                 oor_q;
  logic                 dir_rd_q;
  logic [8:0]           off_q;
  logic [3:0]           cnt_q;
  logic [7:0]           rdata_q;
  logic [7:0]           wdata_q;
  logic                 capture, off_inc, rdata_ld, wdata_ld;
  logic                 lba_oor, last;

  assign lba_oor = (sd_lba >= 32'(NUM_SECTORS));
  assign last    = (off_q == 9'd511);

  always_comb begin
    state_nxt    = state;
    capture      = 1'b0;
    off_inc      = 1'b0;
    rdata_ld     = 1'b0;
    wdata_ld     = 1'b0;
    sd_ack       = 1'b0;
    sd_buff_addr = '0;
    sd_buff_dout = '0;
    sd_buff_wr   = 1'b0;
    mem_addr     = '0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    mem_dout     = '0;
    case (state)
      IDLE: begin
        if (sd_rd || sd_wr) begin
          capture   = 1'b1;
          state_nxt = ACKWAIT;
        end
      end
      ACKWAIT: begin
        if (cnt_q == ACK_LAST) state_nxt = dir_rd_q ? RD_REQ : WR_ADDR;
      end
      RD_REQ: begin
        sd_ack       = 1'b1;
        sd_buff_addr = off_q;
        // Out-of-range sectors never touch the store; the strobe follows immediately.
        if (oor_q) begin
          state_nxt = RD_STB;
        end else begin
          mem_rd    = 1'b1;
          mem_addr  = {lba_q, off_q};
          state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        sd_ack       = 1'b1;
        sd_buff_addr = off_q;
        mem_addr     = {lba_q, off_q};
        if (mem_ready) begin
          rdata_ld  = 1'b1;
          state_nxt = RD_STB;
        end
      end
      RD_STB: begin
        sd_ack       = 1'b1;
        sd_buff_addr = off_q;
        sd_buff_wr   = 1'b1;
        sd_buff_dout = oor_q ? 8'hFF : rdata_q;
        off_inc      = 1'b1;
        state_nxt    = last ? DONE : RD_REQ;
      end
      WR_ADDR: begin
        sd_ack       = 1'b1;
        sd_buff_addr = off_q;
        if (oor_q) begin
          off_inc   = 1'b1;
          state_nxt = last ? DONE : WR_ADDR;
        end else begin
          state_nxt = WR_DATA;
        end
      end
      WR_DATA: begin
        // Buffer data arrives one cycle after the address; forward it and keep a copy for the wait.
        sd_ack       = 1'b1;
        sd_buff_addr = off_q;
        mem_wr       = 1'b1;
        mem_addr     = {lba_q, off_q};
        mem_dout     = sd_buff_din;
        wdata_ld     = 1'b1;
        state_nxt    = WR_WAIT;
      end
      WR_WAIT: begin
        sd_ack       = 1'b1;
        sd_buff_addr = off_q;
        mem_addr     = {lba_q, off_q};
        mem_dout     = wdata_q;
        if (mem_ready) begin
          off_inc   = 1'b1;
          state_nxt = last ? DONE : WR_ADDR;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk_sys) begin
    if (capture) begin
      lba_q    <= sd_lba[LBA_WIDTH-1:0];
      oor_q    <= lba_oor;
      dir_rd_q <= sd_rd;
      off_q    <= '0;
      cnt_q    <= '0;
    end else begin
      if (state == ACKWAIT) cnt_q <= cnt_q + 4'd1;
      if (off_inc)          off_q <= off_q + 9'd1;
    end
    if (rdata_ld) rdata_q <= mem_din;
    if (wdata_ld) wdata_q <= sd_buff_din;
  end

`ifdef SD_SECTOR_RESPONDER_STATS_EN
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rd_sectors <= '0;
      wr_sectors <= '0;
      oor_seen   <= 1'b0;
    end else begin
      if (state == DONE) begin
        if (dir_rd_q && rd_sectors != 16'hFFFF)  rd_sectors <= rd_sectors + 16'd1;
        if (!dir_rd_q && wr_sectors != 16'hFFFF) wr_sectors <= wr_sectors + 16'd1;
      end
      if (capture && lba_oor) oor_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sd_sector_responder.sv
// Randomized bench for sd_sector_responder against a sector-level model of the backing store.
module tb_sd_sector_responder;

  localparam int ACK_DELAY = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din;
  logic [12:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        mem_ready;
`ifdef SD_SECTOR_RESPONDER_STATS_EN
  logic [15:0] rd_sectors, wr_sectors;
  logic        oor_seen;
`endif

  sd_sector_responder #(.LBA_WIDTH(4), .NUM_SECTORS(16), .ACK_DELAY(ACK_DELAY)) dut (
    .clk_sys(clk), .reset(reset), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din),
    .mem_ready(mem_ready)
`ifdef SD_SECTOR_RESPONDER_STATS_EN
    , .rd_sectors(rd_sectors), .wr_sectors(wr_sectors), .oor_seen(oor_seen)
`endif
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         max_lat = 3;
  int         tot_acks = 0;
  int         tot_strobes = 0;
  int         nrd, nmr, nmw;
  logic       cur_oor;
  logic [3:0] cur_idx;
  logic [7:0] wbuf    [0:511];
  logic [7:0] exp_mem [0:8191];
  logic [7:0] store   [0:8191];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Core-side sector buffer: registered read, data one cycle after the address.
  always @(posedge clk) sd_buff_din <= wbuf[sd_buff_addr];

  // Backing store: one response per strobe after a random latency.
  initial begin
    int          pend;
    logic [12:0] a;
    logic        wr_pend;
    pend = 0; a = '0; wr_pend = 1'b0;
    mem_ready = 1'b0; mem_din = 8'h00;
    for (int i = 0; i < 8192; i++) store[i] = i[7:0] ^ {4'h0, i[12:9]};
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mem_ready = 1'b1;
          mem_din   = wr_pend ? 8'($urandom) : store[a];
        end
      end
      if (mem_rd || mem_wr) begin
        a       = mem_addr;
        wr_pend = mem_wr;
        if (mem_wr) store[mem_addr] = mem_dout;
        pend = $urandom_range(1, max_lat);
      end
    end
  end

  task automatic sample();
    if (sd_buff_wr) begin
      check("rd_addr", 32'(sd_buff_addr), 32'(nrd));
      check("rd_data", 32'(sd_buff_dout), cur_oor ? 32'hFF : 32'(exp_mem[{cur_idx, nrd[8:0]}]));
      nrd++;
      tot_strobes++;
    end
    if (mem_rd) begin
      check("mrd_addr", 32'(mem_addr), 32'({cur_idx, nmr[8:0]}));
      nmr++;
    end
    if (mem_wr) begin
      check("mwr_addr", 32'(mem_addr), 32'({cur_idx, nmw[8:0]}));
      check("mwr_data", 32'(mem_dout), 32'(wbuf[nmw[8:0]]));
      nmw++;
    end
  endtask

  // Called at a negedge with the responder idle; returns at a negedge with it idle again.
  task automatic run_xfer(input logic rd, input logic wr, input logic [31:0] lba, input logic rnd);
    int   lat, guard;
    logic is_rd;
    is_rd   = rd;
    cur_oor = (lba >= 32'd16);
    cur_idx = lba[3:0];
    nrd = 0; nmr = 0; nmw = 0;
    for (int k = 0; k < 512; k++) wbuf[k] = rnd ? 8'($urandom) : ~8'(k);
    sd_lba = lba; sd_rd = rd; sd_wr = wr;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!sd_ack && lat < 40);
    sd_rd = 1'b0; sd_wr = 1'b0;
    check("ack_lat", 32'(lat), 32'(ACK_DELAY + 1));
    if (!sd_ack) return;
    tot_acks++;
    guard = 0;
    while (sd_ack && guard < 12000) begin
      sample();
      @(negedge clk);
      guard++;
    end
    check("ack_fall", 32'(sd_ack), 32'd0);
    check("n_strobe", 32'(nrd), is_rd ? 32'd512 : 32'd0);
    check("n_mrd", 32'(nmr), (is_rd && !cur_oor) ? 32'd512 : 32'd0);
    check("n_mwr", 32'(nmw), (!is_rd && !cur_oor) ? 32'd512 : 32'd0);
    if (!is_rd && !cur_oor)
      for (int k = 0; k < 512; k++) exp_mem[{cur_idx, k[8:0]}] = wbuf[k];
    @(negedge clk);
    check("gap_ack", 32'(sd_ack), 32'd0);
  endtask

  initial begin
    int          guard, quiet, acks0, strobes0;
    logic [31:0] rl;
    logic        rr;
`ifdef SD_SECTOR_RESPONDER_STATS_EN
    logic [15:0] rd0;
`endif
    reset = 1'b1; sd_rd = 1'b0; sd_wr = 1'b0; sd_lba = '0;
    for (int k = 0; k < 512; k++) wbuf[k] = 8'h00;
    for (int i = 0; i < 8192; i++) exp_mem[i] = i[7:0] ^ {4'h0, i[12:9]};
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(sd_ack), 0);
    check("rst_bwr", 32'(sd_buff_wr), 0);
    check("rst_mrd", 32'(mem_rd), 0);
    check("rst_mwr", 32'(mem_wr), 0);
    check("rst_baddr", 32'(sd_buff_addr), 0);
    check("rst_maddr", 32'(mem_addr), 0);
    reset = 1'b0;
    @(negedge clk);

    run_xfer(1'b1, 1'b0, 32'd3, 1'b0);
    run_xfer(1'b0, 1'b1, 32'd15, 1'b0);
    run_xfer(1'b1, 1'b0, 32'd15, 1'b0);
    run_xfer(1'b1, 1'b0, 32'd16, 1'b0);
    run_xfer(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
`ifdef SD_SECTOR_RESPONDER_STATS_EN
    check("oor_seen", 32'(oor_seen), 1);
    check("rd_sectors", 32'(rd_sectors), 3);
    check("wr_sectors", 32'(wr_sectors), 2);
`endif
    run_xfer(1'b1, 1'b1, 32'd0, 1'b1);

    // Reset after the 100th strobe of a read.
    cur_oor = 1'b0; cur_idx = 4'd2; nrd = 0; nmr = 0; nmw = 0;
    sd_lba = 32'd2; sd_rd = 1'b1;
    guard = 0;
    while (nrd < 100 && guard < 2000) begin
      @(negedge clk);
      if (sd_ack) sd_rd = 1'b0;
      sample();
      guard++;
    end
    check("pre_rst_cnt", 32'(nrd), 100);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_ack", 32'(sd_ack), 0);
    check("mid_rst_bwr", 32'(sd_buff_wr), 0);
    check("mid_rst_mrd", 32'(mem_rd | mem_wr), 0);
    reset = 1'b0;
    quiet = 0;
    repeat (20) begin
      @(negedge clk);
      if (sd_ack || sd_buff_wr || mem_rd || mem_wr) quiet++;
    end
    check("post_rst_quiet", 32'(quiet), 0);
`ifdef SD_SECTOR_RESPONDER_STATS_EN
    check("rst_rd_sectors", 32'(rd_sectors), 0);
    check("rst_oor_seen", 32'(oor_seen), 0);
`endif
    run_xfer(1'b1, 1'b0, 32'd1, 1'b1);

    max_lat = 1;
    acks0 = tot_acks; strobes0 = tot_strobes;
`ifdef SD_SECTOR_RESPONDER_STATS_EN
    rd0 = rd_sectors;
`endif
    for (int i = 0; i < 16; i++) run_xfer(1'b1, 1'b0, 32'(i), 1'b1);
    check("b2b_acks", 32'(tot_acks - acks0), 16);
    check("b2b_strobes", 32'(tot_strobes - strobes0), 8192);
`ifdef SD_SECTOR_RESPONDER_STATS_EN
    check("b2b_rd_sectors", 32'(rd_sectors - rd0), 16);
`endif

    max_lat = 2;
    repeat (3) begin
      rr = 1'($urandom);
      rl = ($urandom_range(0, 3) == 0) ? 32'($urandom) | 32'h10 : 32'($urandom_range(0, 15));
      run_xfer(rr, ~rr, rl, 1'b1);
    end
    run_xfer(1'b1, 1'b0, 32'($urandom_range(0, 15)), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_sector_responder.md
Name: sd_sector_responder

Overview:
- Target side of the core's SD sector-buffer interface: sd_lba, sd_rd, sd_wr, sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_din, sd_buff_wr.
- Serves sector requests from the backup-RAM save/load state machine against a local byte-addressed backing store.
- Replaces the SPI host path in standalone builds and simulation, so save/load works without the firmware.
- Sits between the core's backup-RAM controller and a single-port byte memory (BRAM or SDRAM port).

Parameters:
- LBA_WIDTH, 4: sector-index bits used for addressing; backing store holds 2**LBA_WIDTH sectors.
- NUM_SECTORS, 16: sectors present; an LBA at or above this value is out of range.
- ACK_DELAY, 2: clk_sys cycles from request capture to sd_ack rise. Legal range 1..15.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sd_lba  in  32  sector number; sampled at request capture.
- sd_rd  in  1  read request, level.
- sd_wr  in  1  write request, level.
- sd_ack  out  1  high for the whole transfer.
- sd_buff_addr  out  9  byte offset within the sector.
- sd_buff_dout  out  8  read data sent to the core.
- sd_buff_wr  out  1  one-cycle strobe: sd_buff_dout is valid at sd_buff_addr.
- sd_buff_din  in  8  write data from the core's buffer; valid 1 cycle after sd_buff_addr.
- mem_addr  out  LBA_WIDTH+9  backing-store byte address, {lba, offset}.
- mem_rd  out  1  backing-store read strobe.
- mem_wr  out  1  backing-store write strobe.
- mem_dout  out  8  write data to the backing store.
- mem_din  in  8  read data from the backing store; valid when mem_ready is high.
- mem_ready  in  1  access-complete strobe; one pulse per strobe issued.

Behaviour:
- Reset: all outputs 0, state IDLE. A reset mid-transfer aborts immediately; sd_ack falls on the next edge and no further mem strobes are issued.
- IDLE:
  - sd_rd=1 or sd_wr=1 → latch sd_lba[LBA_WIDTH-1:0], an out-of-range flag (sd_lba >= NUM_SECTORS, compared on the full 32 bits) and direction.
  - Both sd_rd and sd_wr high: read wins.
  - Offset counter cleared, go to ACKWAIT.
- ACKWAIT: count ACK_DELAY cycles, then assert sd_ack and enter RD_REQ or WR_ADDR. The initiator drops its request on the rising edge of sd_ack; request levels are ignored until the next IDLE.
- Read path, per byte:
  - RD_REQ: mem_addr={lba,off}, mem_rd=1 for one cycle.
  - RD_WAIT: hold until mem_ready. Then sd_buff_dout=mem_din, sd_buff_addr=off, sd_buff_wr=1 for exactly one cycle; sd_buff_addr and sd_buff_dout stay stable during the strobe.
  - Out of range: skip memory, return 8'hFF, strobe 1 cycle after RD_REQ.
- Write path, per byte:
  - WR_ADDR: drive sd_buff_addr=off.
  - WR_DATA (next cycle): capture sd_buff_din, issue mem_wr=1 for one cycle with mem_dout=captured value.
  - WR_WAIT: hold until mem_ready.
  - Out of range: data is discarded and no mem_wr is issued; one cycle per byte.
- Offset: 9-bit, increments after each byte. When the byte at off=511 completes, go to DONE; the offset wraps to 0, never to 512.
- DONE: sd_ack=0 for one cycle, then IDLE. The initiator sees sd_ack fall exactly once per sector. Minimum gap between sectors is 1 IDLE cycle plus ACK_DELAY.
- mem_ready arriving outside a wait state is ignored.
- At most one mem strobe is outstanding at any time.

Optional Feature:
- Macro: SD_SECTOR_RESPONDER_STATS_EN.
- Defined:
  - Extra output ports rd_sectors[15:0] and wr_sectors[15:0], plus status output oor_seen (1 bit).
  - Counters increment in DONE, saturate at 16'hFFFF, and clear on reset.
  - oor_seen is sticky and sets on any out-of-range request.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Read, in range: backing store preloaded with byte = offset[7:0] ^ lba. sd_rd=1, sd_lba=3, mem_ready 2 cycles after each mem_rd. Expect:
  - sd_ack rises 2 cycles after capture.
  - 512 sd_buff_wr pulses, addresses 0..511 in order, data offset^3.
  - sd_ack falls once; mem_addr range 0x600..0x7FF.
- Write, in range: sd_wr=1, sd_lba=15, core buffer returns ~addr[7:0] with 1-cycle latency. Expect 512 mem_wr at 0x1E00..0x1FFF with mem_dout=~offset, and no sd_buff_wr pulses.
- Out of range:
  - sd_rd at lba=16: all 512 bytes are 8'hFF and mem_rd never asserts.
  - sd_wr at lba=0x100000000-1: no mem_wr.
  - With the macro defined, oor_seen=1.
- Simultaneous sd_rd=1 and sd_wr=1 at lba=0: expect a read transfer and no mem_wr.
- Reset mid-transfer: assert reset after the 100th sd_buff_wr. Expect:
  - Next cycle sd_ack=0 and all strobes 0, with no further strobes.
  - A new sd_rd at lba=1 completes a full 512-byte transfer.
- Back-to-back: 16 sequential read requests, lba 0..15, issued as in the core's load flow. Expect 16 ack pulses and 8192 strobes total; with the macro defined, rd_sectors=16.
